// File: rtl/memb_readback.sv
// Read-side drain controller for memory B: walks addresses 0..DEPTH-1, reads each
// word through the memory's one-cycle read port and hands it out on a valid/ready stream.
module memb_readback #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] addrB,
  output logic              reB,
  input  logic [DATA_W-1:0] doutB,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DONE
  } stateT;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  stateT             state;
  stateT             nextState;
  logic [ADDR_W-1:0] wordCount;
  logic              accepted;

  assign accepted = (state == SEND) && dout_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = READ;
      READ: nextState = WAIT;
      WAIT: nextState = SEND;
      SEND: begin
        if (dout_ready) begin
          nextState = (wordCount == LAST_ADDR) ? DONE : READ;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The counter is the read address; it only advances on an accepted non-final word,
  // so it never wraps within a transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      wordCount <= '0;
    end else if ((state == IDLE) && start) begin
      wordCount <= '0;
    end else if (accepted && (wordCount != LAST_ADDR)) begin
      wordCount <= wordCount + 1'b1;
    end
  end

  // Memory data is captured once, at the end of WAIT, and held through SEND.
  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= '0;
    end else if (state == WAIT) begin
      dout <= doutB;
    end
  end

  always_comb begin
    reB        = 1'b0;
    dout_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE:    busy       = 1'b0;
      READ:    reB        = 1'b1;
      SEND:    dout_valid = 1'b1;
      DONE:    done       = 1'b1;
      default: ;
    endcase
  end

  assign addrB = wordCount;

endmodule

// File: doc/memb_readback.md
Name: memb_readback

Overview:
- Read-side controller for memory B: the drain path opposite the write-side transfer controller.
- On `start`, it walks memory B addresses 0..DEPTH-1 through its own address counter and issues one read per word.
- Each returned word is captured and presented on a valid/ready output stream to a downstream consumer.
- It asserts a one-cycle `done` after the last word is accepted. It sits alongside memory B, using the memory's read port.

Parameters:
- DATA_W, 8, width of memory B words and of the output stream.
- ADDR_W, 2, memory B address width.
- DEPTH, 4, number of words drained per transfer; must be ≤ 2^ADDR_W.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a drain; sampled only in IDLE.
- addrB  output  ADDR_W  read address to memory B.
- reB  output  1  read enable to memory B; data returns on doutB one cycle later.
- doutB  input  DATA_W  memory B read data, valid the cycle after reB.
- dout  output  DATA_W  stream data to consumer.
- dout_valid  output  1  dout holds a word not yet accepted.
- dout_ready  input  1  consumer accepts when dout_valid && dout_ready at a clock edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset
  - Any cycle with reset=1 forces the FSM to IDLE on that edge.
  - Reset values: word counter=0, addrB=0, reB=0, dout=0, dout_valid=0, busy=0, done=0.
  - Reset mid-transfer abandons the transfer; no done pulse follows.
- FSM states: IDLE, READ, WAIT, SEND, DONE.
- IDLE
  - reB=0, dout_valid=0.
  - start=1 → counter=0, go to READ.
  - start=0 → stay.
- READ
  - reB=1 for exactly this cycle; addrB=counter.
  - Next state is WAIT.
- WAIT
  - reB=0.
  - At the edge, dout ← doutB and dout_valid ← 1; go to SEND.
- SEND
  - dout and dout_valid are held stable until accepted; dout must not change while dout_valid=1 and dout_ready=0.
  - On an edge with dout_ready=1: dout_valid ← 0.
    - If counter==DEPTH-1 → DONE.
    - Otherwise counter ← counter+1 → READ.
  - dout_ready=0 → stay indefinitely.
- DONE
  - done=1 for exactly this cycle; busy=1.
  - Next state is IDLE unconditionally.
- Outputs and timing
  - addrB always equals the counter.
  - Counter width is ADDR_W; it never wraps within a transfer and is cleared on every start.
  - Latency from start to first dout_valid: 3 clock edges (IDLE→READ→WAIT→SEND).
  - Best-case throughput is one word per 3 cycles.
  - Minimum transfer time with dout_ready held high: 3·DEPTH+1 cycles from start to the done pulse.
- Ignored or don't-care inputs
  - start in any state other than IDLE is ignored; it is not queued.
  - dout_ready outside SEND is ignored.
  - doutB is don't-care except during WAIT.
- Simultaneous events
  - start and reset in the same cycle: reset wins.
  - start in the same cycle as the done pulse is ignored.
  - Once back in IDLE, a new start is accepted.
- Data handling: words are passed unmodified, with no width conversion or arithmetic.

Test Plan:
- Preload memory B with {0x11,0x22,0x33,0x44}; pulse start; hold dout_ready=1.
  - dout sequence must be 0x11, 0x22, 0x33, 0x44.
  - addrB sequence must be 0,1,2,3.
  - done must pulse exactly once, 13 cycles after start.
  - busy must be high for cycles 1–13.
- Same preload; dout_ready held low 5 cycles on word 0x22.
  - dout stays 0x22 and dout_valid stays 1 throughout the stall.
  - No extra reB pulse may occur during the stall.
  - Remaining words arrive in order; done fires 5 cycles later than in the unstalled case.
- Pulse start again while busy, in READ and in SEND states.
  - The transfer is unaffected: exactly 4 words and one done.
  - No second transfer follows.
- Assert reset while in SEND holding word 0x33.
  - Next cycle: dout_valid=0, busy=0, addrB=0, reB=0; no done pulse.
  - A subsequent start re-reads from address 0 (0x11 first).
- Assert start and reset together from IDLE → block remains IDLE, reB never asserts.
- Back-to-back transfers: a start on the first cycle after done returns to IDLE → the second transfer emits the full 4-word sequence again, and done pulses once per transfer.
